hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipeline. It succeeds the separate combinational hazard-detection and forward units.
- Adds the following over those units:
  - multi-cycle load-use stall, driven by a counter FSM;
  - ID-stage branch operand hazards with branch forwarding;
  - taken-branch IF/ID flush;
  - global memory-stall freeze;
  - saturating stall-cycle performance counter.
- Sits beside the ID stage. Drives PC enable, IF/ID write/flush, ID/EX bubble mux and EX/ID forwarding muxes.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 60 ++++++
 rtl/hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller.
// Forwarding mux encodings, FSM state type and the default register-address width.
package pipeline_pkg;
    localparam int DEF_REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: stage register fields in, stall/flush/forward controls out.
// All signals are level-valued per cycle; there is no valid/ready handshake on this bundle.
interface hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int REG_W  = DEF_REG_W,
    parameter int PERF_W = 16,
    parameter int CNT_W  = 3
);
    logic             mem_stall;
    logic             branch_taken;
    logic             if_id_is_branch;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             id_ex_MemRead;
    logic             id_ex_RegWrite;
    logic [REG_W-1:0] id_ex_rd;
    logic [REG_W-1:0] id_ex_rs;
    logic [REG_W-1:0] id_ex_rt;
    logic             ex_mem_MemRead;
    logic             ex_mem_RegWrite;
    logic [REG_W-1:0] ex_mem_rd;
    logic             mem_wb_RegWrite;
    logic [REG_W-1:0] mem_wb_rd;
    logic             perf_clr;

    logic              PCWrite;
    logic              if_id_Write;
    logic              if_id_Flush;
    logic              mux_Ctrl;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              ForwardBrA;
    logic              ForwardBrB;
    logic [PERF_W-1:0] stall_cycles;

    // Debug view of the stall FSM.
    state_e            state_dbg;
    logic [CNT_W-1:0]  cnt_dbg;

    modport master (
        output mem_stall, branch_taken, if_id_is_branch, if_id_rs, if_id_rt,
               id_ex_MemRead, id_ex_RegWrite, id_ex_rd, id_ex_rs, id_ex_rt,
               ex_mem_MemRead, ex_mem_RegWrite, ex_mem_rd,
               mem_wb_RegWrite, mem_wb_rd, perf_clr,
        input  PCWrite, if_id_Write, if_id_Flush, mux_Ctrl,
               ForwardA, ForwardB, ForwardBrA, ForwardBrB, stall_cycles,
               state_dbg, cnt_dbg
    );

    modport slave (
        input  mem_stall, branch_taken, if_id_is_branch, if_id_rs, if_id_rt,
               id_ex_MemRead, id_ex_RegWrite, id_ex_rd, id_ex_rs, id_ex_rt,
               ex_mem_MemRead, ex_mem_RegWrite, ex_mem_rd,
               mem_wb_RegWrite, mem_wb_rd, perf_clr,
        output PCWrite, if_id_Write, if_id_Flush, mux_Ctrl,
               ForwardA, ForwardB, ForwardBrA, ForwardBrB, stall_cycles,
               state_dbg, cnt_dbg
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand EX forwarding select: EX/MEM result beats MEM/WB, register 0 never forwards.
module fwd_sel
    import pipeline_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             ex_mem_RegWrite,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             mem_wb_RegWrite,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic [REG_W-1:0] src,
    output logic [1:0]       fwd
);
    always_comb begin
        fwd = FWD_RF;
        if (ex_mem_RegWrite && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
            fwd = FWD_EXMEM;
        end else if (mem_wb_RegWrite && (mem_wb_rd != '0) && (mem_wb_rd == src)) begin
            fwd = FWD_MEMWB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage: load-use / branch-operand stalls,
// taken-branch flush, memory freeze, EX and ID-branch forwarding, saturating stall counter.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W          = DEF_REG_W,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 3,
    parameter int PERF_W         = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hif
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q;

    logic lu, bh, stall;
    logic pc_write, ifid_write, mux_ctrl;

    always_comb begin
        lu = hif.id_ex_MemRead && (hif.id_ex_rd != '0) &&
             ((hif.id_ex_rd == hif.if_id_rs) || (hif.id_ex_rd == hif.if_id_rt));
        bh = hif.if_id_is_branch && (
                 (hif.id_ex_RegWrite && (hif.id_ex_rd != '0) &&
                  ((hif.id_ex_rd == hif.if_id_rs) || (hif.id_ex_rd == hif.if_id_rt))) ||
                 (hif.ex_mem_MemRead && (hif.ex_mem_rd != '0) &&
                  ((hif.ex_mem_rd == hif.if_id_rs) || (hif.ex_mem_rd == hif.if_id_rt))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_stall freezes everything (state, count) but lets ID/EX control pass unchanged.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        mux_ctrl   = 1'b1;
        if (hif.mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall = lu || bh;
                    if (lu && (LOAD_USE_STALL > 1)) begin
                        state_d = LU_STALL;
                        cnt_d   = CNT_W'(LOAD_USE_STALL - 1);
                    end
                end
                LU_STALL: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                mux_ctrl   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (hif.perf_clr) begin
            perf_q <= '0;
        end else if (!pc_write && (perf_q != {PERF_W{1'b1}})) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .ex_mem_RegWrite (hif.ex_mem_RegWrite),
        .ex_mem_rd       (hif.ex_mem_rd),
        .mem_wb_RegWrite (hif.mem_wb_RegWrite),
        .mem_wb_rd       (hif.mem_wb_rd),
        .src             (hif.id_ex_rs),
        .fwd             (hif.ForwardA)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .ex_mem_RegWrite (hif.ex_mem_RegWrite),
        .ex_mem_rd       (hif.ex_mem_rd),
        .mem_wb_RegWrite (hif.mem_wb_RegWrite),
        .mem_wb_rd       (hif.mem_wb_rd),
        .src             (hif.id_ex_rt),
        .fwd             (hif.ForwardB)
    );

    // A load result is not yet available in EX/MEM, so branch forwarding excludes loads.
    assign hif.ForwardBrA = hif.ex_mem_RegWrite && !hif.ex_mem_MemRead &&
                            (hif.ex_mem_rd != '0) && (hif.ex_mem_rd == hif.if_id_rs);
    assign hif.ForwardBrB = hif.ex_mem_RegWrite && !hif.ex_mem_MemRead &&
                            (hif.ex_mem_rd != '0) && (hif.ex_mem_rd == hif.if_id_rt);

    assign hif.PCWrite      = pc_write;
    assign hif.if_id_Write  = ifid_write;
    assign hif.mux_Ctrl     = mux_ctrl;
    assign hif.if_id_Flush  = hif.branch_taken && !stall && !hif.mem_stall;
    assign hif.stall_cycles = perf_q;
    assign hif.state_dbg    = state_q;
    assign hif.cnt_dbg      = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_USE_STALL=3/PERF_W=16 and LOAD_USE_STALL=1/PERF_W=4)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       mem_stall, branch_taken, if_id_is_branch;
    logic [4:0] if_id_rs, if_id_rt;
    logic       id_ex_MemRead, id_ex_RegWrite;
    logic [4:0] id_ex_rd, id_ex_rs, id_ex_rt;
    logic       ex_mem_MemRead, ex_mem_RegWrite;
    logic [4:0] ex_mem_rd;
    logic       mem_wb_RegWrite;
    logic [4:0] mem_wb_rd;
    logic       perf_clr;

    hazard_ctrl_if #(.REG_W(5), .PERF_W(16), .CNT_W(3)) hif_a ();
    hazard_ctrl_if #(.REG_W(5), .PERF_W(4),  .CNT_W(3)) hif_b ();

    assign hif_a.mem_stall = mem_stall;         assign hif_b.mem_stall = mem_stall;
    assign hif_a.branch_taken = branch_taken;   assign hif_b.branch_taken = branch_taken;
    assign hif_a.if_id_is_branch = if_id_is_branch; assign hif_b.if_id_is_branch = if_id_is_branch;
    assign hif_a.if_id_rs = if_id_rs;           assign hif_b.if_id_rs = if_id_rs;
    assign hif_a.if_id_rt = if_id_rt;           assign hif_b.if_id_rt = if_id_rt;
    assign hif_a.id_ex_MemRead = id_ex_MemRead; assign hif_b.id_ex_MemRead = id_ex_MemRead;
    assign hif_a.id_ex_RegWrite = id_ex_RegWrite; assign hif_b.id_ex_RegWrite = id_ex_RegWrite;
    assign hif_a.id_ex_rd = id_ex_rd;           assign hif_b.id_ex_rd = id_ex_rd;
    assign hif_a.id_ex_rs = id_ex_rs;           assign hif_b.id_ex_rs = id_ex_rs;
    assign hif_a.id_ex_rt = id_ex_rt;           assign hif_b.id_ex_rt = id_ex_rt;
    assign hif_a.ex_mem_MemRead = ex_mem_MemRead; assign hif_b.ex_mem_MemRead = ex_mem_MemRead;
    assign hif_a.ex_mem_RegWrite = ex_mem_RegWrite; assign hif_b.ex_mem_RegWrite = ex_mem_RegWrite;
    assign hif_a.ex_mem_rd = ex_mem_rd;         assign hif_b.ex_mem_rd = ex_mem_rd;
    assign hif_a.mem_wb_RegWrite = mem_wb_RegWrite; assign hif_b.mem_wb_RegWrite = mem_wb_RegWrite;
    assign hif_a.mem_wb_rd = mem_wb_rd;         assign hif_b.mem_wb_rd = mem_wb_rd;
    assign hif_a.perf_clr = perf_clr;           assign hif_b.perf_clr = perf_clr;

    hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(3), .CNT_W(3), .PERF_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .hif(hif_a.slave));
    hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(1), .CNT_W(3), .PERF_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .hif(hif_b.slave));

    // Actual outputs gathered per instance.
    logic        act_pc[2], act_ifw[2], act_fl[2], act_mux[2], act_bra[2], act_brb[2];
    logic [1:0]  act_fa[2], act_fb[2];
    logic [15:0] act_perf[2];
    assign act_pc[0] = hif_a.PCWrite;      assign act_pc[1] = hif_b.PCWrite;
    assign act_ifw[0] = hif_a.if_id_Write; assign act_ifw[1] = hif_b.if_id_Write;
    assign act_fl[0] = hif_a.if_id_Flush;  assign act_fl[1] = hif_b.if_id_Flush;
    assign act_mux[0] = hif_a.mux_Ctrl;    assign act_mux[1] = hif_b.mux_Ctrl;
    assign act_bra[0] = hif_a.ForwardBrA;  assign act_bra[1] = hif_b.ForwardBrA;
    assign act_brb[0] = hif_a.ForwardBrB;  assign act_brb[1] = hif_b.ForwardBrB;
    assign act_fa[0] = hif_a.ForwardA;     assign act_fa[1] = hif_b.ForwardA;
    assign act_fb[0] = hif_a.ForwardB;     assign act_fb[1] = hif_b.ForwardB;
    assign act_perf[0] = hif_a.stall_cycles;
    assign act_perf[1] = {12'd0, hif_b.stall_cycles};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lus[2]  = '{3, 1};
    int pmax[2] = '{65535, 15};
    int rem[2];   // bubbles still owed after the current cycle
    int perf[2];

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (ex_mem_RegWrite && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
        if (mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic reads(input logic [4:0] r);
        return r != 0 && (r == if_id_rs || r == if_id_rt);
    endfunction

    logic m_lu, m_bh, m_stall, e_pc, e_mux, e_fl, e_bra, e_brb;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rem[d]  = 0;
                perf[d] = 0;
            end
            m_lu = id_ex_MemRead && reads(id_ex_rd);
            m_bh = if_id_is_branch && ((id_ex_RegWrite && reads(id_ex_rd)) ||
                                       (ex_mem_MemRead && reads(ex_mem_rd)));
            m_stall = 1'b0;
            if (!mem_stall) m_stall = (rem[d] > 0) ? 1'b1 : (m_lu || m_bh);
            e_pc  = !mem_stall && !m_stall;
            e_mux = mem_stall || !m_stall;
            e_fl  = branch_taken && !m_stall && !mem_stall;
            e_bra = ex_mem_RegWrite && !ex_mem_MemRead && ex_mem_rd != 0 && ex_mem_rd == if_id_rs;
            e_brb = ex_mem_RegWrite && !ex_mem_MemRead && ex_mem_rd != 0 && ex_mem_rd == if_id_rt;

            check($sformatf("d%0d_PCWrite", d), 32'(act_pc[d]), 32'(e_pc));
            check($sformatf("d%0d_if_id_Write", d), 32'(act_ifw[d]), 32'(e_pc));
            check($sformatf("d%0d_mux_Ctrl", d), 32'(act_mux[d]), 32'(e_mux));
            check($sformatf("d%0d_if_id_Flush", d), 32'(act_fl[d]), 32'(e_fl));
            check($sformatf("d%0d_ForwardA", d), 32'(act_fa[d]), 32'(fwd_model(id_ex_rs)));
            check($sformatf("d%0d_ForwardB", d), 32'(act_fb[d]), 32'(fwd_model(id_ex_rt)));
            check($sformatf("d%0d_ForwardBrA", d), 32'(act_bra[d]), 32'(e_bra));
            check($sformatf("d%0d_ForwardBrB", d), 32'(act_brb[d]), 32'(e_brb));
            check($sformatf("d%0d_stall_cycles", d), 32'(act_perf[d]), 32'(perf[d]));

            if (rst_n) begin
                if (!mem_stall) begin
                    if (rem[d] > 0) rem[d] = rem[d] - 1;
                    else if (m_lu && lus[d] > 1) rem[d] = lus[d] - 1;
                end
                if (perf_clr) perf[d] = 0;
                else if (!e_pc && perf[d] < pmax[d]) perf[d] = perf[d] + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        mem_stall = 0; branch_taken = 0; if_id_is_branch = 0;
        if_id_rs = 0; if_id_rt = 0;
        id_ex_MemRead = 0; id_ex_RegWrite = 0; id_ex_rd = 0; id_ex_rs = 0; id_ex_rt = 0;
        ex_mem_MemRead = 0; ex_mem_RegWrite = 0; ex_mem_rd = 0;
        mem_wb_RegWrite = 0; mem_wb_rd = 0; perf_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        id_ex_MemRead = 1; id_ex_rd = r; if_id_rs = r;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            clear_inputs();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        check("reset_PCWrite", 32'(hif_a.PCWrite), 32'd1);
        check("reset_mux_Ctrl", 32'(hif_a.mux_Ctrl), 32'd1);
        check("reset_Flush", 32'(hif_a.if_id_Flush), 32'd0);
        check("reset_ForwardA", 32'(hif_a.ForwardA), 32'd0);
        check("reset_state", 32'(hif_a.state_dbg), 32'(IDLE));
        check("reset_stall_cycles", 32'(hif_a.stall_cycles), 32'd0);
        step();
        rst_n = 1;
        idle_cycles(2);

        // Load-use: lw r8 in EX, ID reads r8.
        step();
        set_load_use(5'd8);
        @(negedge clk);
        check("lu1_PCWrite", 32'(hif_b.PCWrite), 32'd0);
        check("lu1_mux_Ctrl", 32'(hif_b.mux_Ctrl), 32'd0);
        check("lu3_first_PCWrite", 32'(hif_a.PCWrite), 32'd0);
        step();
        clear_inputs();
        #1;
        check("lu1_released", 32'(hif_b.PCWrite), 32'd1);
        check("lu1_stall_cycles", 32'(hif_b.stall_cycles), 32'd1);
        check("lu3_second_PCWrite", 32'(hif_a.PCWrite), 32'd0);
        check("lu3_state", 32'(hif_a.state_dbg), 32'(LU_STALL));
        // Asynchronous reset in the middle of the stall.
        rst_n = 0;
        #1;
        check("rst_mid_PCWrite", 32'(hif_a.PCWrite), 32'd1);
        check("rst_mid_mux_Ctrl", 32'(hif_a.mux_Ctrl), 32'd1);
        check("rst_mid_state", 32'(hif_a.state_dbg), 32'(IDLE));
        @(negedge clk);
        step();
        rst_n = 1;
        idle_cycles(1);

        // Full 3-bubble load-use on dut_a.
        step();
        set_load_use(5'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lu3_bubble", 32'(hif_a.mux_Ctrl), 32'd0);
            step();
            clear_inputs();
        end
        #1;
        check("lu3_done", 32'(hif_a.PCWrite), 32'd1);

        // Forwarding priority and register 0.
        ex_mem_RegWrite = 1; ex_mem_rd = 5; mem_wb_RegWrite = 1; mem_wb_rd = 5; id_ex_rs = 5;
        #1;
        check("fwd_exmem_prio", 32'(hif_a.ForwardA), 32'd2);
        ex_mem_RegWrite = 0;
        #1;
        check("fwd_memwb", 32'(hif_a.ForwardA), 32'd1);
        mem_wb_rd = 0; id_ex_rt = 0;
        #1;
        check("fwd_r0", 32'(hif_a.ForwardB), 32'd0);
        idle_cycles(1);

        // Branch operand hazard, then branch forwarding and flush.
        if_id_is_branch = 1; if_id_rs = 9; id_ex_RegWrite = 1; id_ex_rd = 9; branch_taken = 1;
        @(negedge clk);
        check("bh_PCWrite", 32'(hif_a.PCWrite), 32'd0);
        check("bh_no_flush", 32'(hif_a.if_id_Flush), 32'd0);
        step();
        id_ex_RegWrite = 0; id_ex_rd = 0; ex_mem_RegWrite = 1; ex_mem_rd = 9;
        @(negedge clk);
        check("br_fwdA", 32'(hif_a.ForwardBrA), 32'd1);
        check("br_flush", 32'(hif_a.if_id_Flush), 32'd1);
        idle_cycles(2);

        // mem_stall freezes a load-use stall with two bubbles left.
        step();
        set_load_use(5'd8);
        step();
        clear_inputs();
        mem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ms_cnt_hold", 32'(hif_a.cnt_dbg), 32'd2);
            check("ms_mux_Ctrl", 32'(hif_a.mux_Ctrl), 32'd1);
            step();
            mem_stall = (i < 3);
        end
        @(negedge clk);
        check("ms_resume", 32'(hif_a.mux_Ctrl), 32'd0);
        idle_cycles(2);
        @(negedge clk);
        check("ms_done", 32'(hif_a.PCWrite), 32'd1);

        // Saturation: 2^4+5 stall cycles on the 4-bit counter.
        step();
        set_load_use(5'd8);
        perf_clr = 1;
        for (int i = 0; i < 21; i++) begin
            step();
            perf_clr = 0;
        end
        @(negedge clk);
        check("sat_b", 32'(hif_b.stall_cycles), 32'd15);
        check("sat_a", 32'(hif_a.stall_cycles), 32'd20);
        step();
        clear_inputs();
        perf_clr = 1;
        step();
        perf_clr = 0;
        @(negedge clk);
        check("perf_clr_a", 32'(hif_a.stall_cycles), 32'd0);
        check("perf_clr_b", 32'(hif_b.stall_cycles), 32'd0);
        idle_cycles(3);

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step();
            mem_stall       = ($urandom_range(0, 5) == 0);
            branch_taken    = ($urandom_range(0, 3) == 0);
            if_id_is_branch = ($urandom_range(0, 2) == 0);
            if_id_rs        = 5'($urandom_range(0, 3));
            if_id_rt        = 5'($urandom_range(0, 3));
            id_ex_MemRead   = ($urandom_range(0, 3) == 0);
            id_ex_RegWrite  = ($urandom_range(0, 1) == 0);
            id_ex_rd        = 5'($urandom_range(0, 3));
            id_ex_rs        = 5'($urandom_range(0, 3));
            id_ex_rt        = 5'($urandom_range(0, 3));
            ex_mem_MemRead  = ($urandom_range(0, 3) == 0);
            ex_mem_RegWrite = ($urandom_range(0, 1) == 0);
            ex_mem_rd       = 5'($urandom_range(0, 3));
            mem_wb_RegWrite = ($urandom_range(0, 1) == 0);
            mem_wb_rd       = 5'($urandom_range(0, 3));
            perf_clr        = ($urandom_range(0, 63) == 0);
        end
        idle_cycles(4);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
